// File: rtl/mca_pkg.sv
// ---------------------------------------------------------------------------
// mca_pkg
// Shared definitions for the multichannel-analyser histogram block:
//   - state_e      : acquisition FSM states
//   - CH_BITS_DEF  : default channel address width (2**CH_BITS_DEF bins)
//   - CNT_BITS_DEF : default per-bin / total counter width
//   - CNT_MAX      : saturation value for a default-width counter
// ---------------------------------------------------------------------------
package mca_pkg;

    localparam int CH_BITS_DEF  = 10;
    localparam int CNT_BITS_DEF = 32;

    localparam logic [CNT_BITS_DEF-1:0] CNT_MAX = {CNT_BITS_DEF{1'b1}};

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_RUN
    } state_e;

endpackage

// File: rtl/mca_histogram_if.sv
// ---------------------------------------------------------------------------
// mca_histogram_if
// Bundles the command, event and host-read signals between the histogram
// and its neighbours (event source + USB command block).
//   master : drives cmd_*, event_*, channel_address; observes status/counts
//   slave  : the histogram itself
// ---------------------------------------------------------------------------
interface mca_histogram_if
    import mca_pkg::*;
#(
    parameter int CH_BITS  = CH_BITS_DEF,
    parameter int CNT_BITS = CNT_BITS_DEF
);

    logic                cmd_start;
    logic                cmd_pause;
    logic                cmd_clear;
    logic                event_valid;
    logic [CH_BITS-1:0]  event_channel;
    logic [CH_BITS-1:0]  channel_address;
    logic [CNT_BITS-1:0] channel_count;
    logic                running;
    logic                clearing;
    logic [CNT_BITS-1:0] total_events;

    modport master (
        output cmd_start, cmd_pause, cmd_clear,
        output event_valid, event_channel, channel_address,
        input  channel_count, running, clearing, total_events
    );

    modport slave (
        input  cmd_start, cmd_pause, cmd_clear,
        input  event_valid, event_channel, channel_address,
        output channel_count, running, clearing, total_events
    );

endinterface

// File: rtl/mca_dpram.sv
// ---------------------------------------------------------------------------
// mca_dpram
// Histogram bin storage, 2**AW words of DW bits, no reset.
//   clk_i                  : clock
//   a_we_i/a_waddr_i/a_wdata_i : port-A write (increment write-back, clear)
//   a_raddr_i/a_rdata_o    : port-A registered read (increment fetch)
//   b_addr_i/b_rdata_o     : port-B registered read-only (host)
// Reads that collide with a same-edge write return the old word. Port A
// reads and writes different addresses in the same cycle (fetch of the
// next event while writing back the previous one), so its read and write
// addresses are separate inputs.
// ---------------------------------------------------------------------------
module mca_dpram #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          a_we_i,
    input  logic [AW-1:0] a_waddr_i,
    input  logic [DW-1:0] a_wdata_i,
    input  logic [AW-1:0] a_raddr_i,
    output logic [DW-1:0] a_rdata_o,
    input  logic [AW-1:0] b_addr_i,
    output logic [DW-1:0] b_rdata_o
);

    // NOTE: the array and its read registers carry no reset so they map onto
    // block RAM; the top's clear sweep gives the contents a defined value.
    logic [DW-1:0] mem [0:(2**AW)-1];

    always_ff @(posedge clk_i) begin
        if (a_we_i) begin
            mem[a_waddr_i] <= a_wdata_i;
        end
        a_rdata_o <= mem[a_raddr_i];
    end

    always_ff @(posedge clk_i) begin
        b_rdata_o <= mem[b_addr_i];
    end

endmodule

// File: rtl/mca_histogram.sv
// ---------------------------------------------------------------------------
// mca_histogram
// Multichannel-analyser histogram: bins event channel codes into saturating
// per-channel counters and answers host reads.
//   CLOCK_50 : sole clock
//   rst_n    : asynchronous active-low reset (starts a clear sweep)
//   bus      : mca_histogram_if.slave -- commands, events, host read port,
//              running/clearing status and total_events
// Increment path: cycle t fetches the bin, cycle t+1 (stage B) adds one with
// saturation and writes back. The last write is kept in a forwarding
// register because the RAM fetch issued on the same edge sees old data.
// ---------------------------------------------------------------------------
module mca_histogram
    import mca_pkg::*;
#(
    parameter int CH_BITS  = CH_BITS_DEF,
    parameter int CNT_BITS = CNT_BITS_DEF
) (
    input  logic             CLOCK_50,
    input  logic             rst_n,
    mca_histogram_if.slave   bus
);

    localparam logic [CNT_BITS-1:0] CNT_FULL = {CNT_BITS{1'b1}};
    localparam logic [CH_BITS-1:0]  ADDR_LAST = {CH_BITS{1'b1}};

    state_e              state_q, state_d;
    logic [CH_BITS-1:0]  sweep_q, sweep_d;
    logic [CNT_BITS-1:0] total_q, total_d;

    logic                b_valid_q;
    logic [CH_BITS-1:0]  b_addr_q;
    logic                fwd_valid_q;
    logic [CH_BITS-1:0]  fwd_addr_q;
    logic [CNT_BITS-1:0] fwd_value_q;
    logic                rd_valid_q;

    logic                accept;
    logic                b_write;
    logic [CNT_BITS-1:0] src;
    logic [CNT_BITS-1:0] inc_value;
    logic [CNT_BITS-1:0] ram_rdata_a;
    logic [CNT_BITS-1:0] ram_rdata_b;
    logic                ram_we;
    logic [CH_BITS-1:0]  ram_waddr;
    logic [CNT_BITS-1:0] ram_wdata;

    assign accept    = bus.event_valid && (state_q == ST_RUN);
    // A write-back landing on the edge that enters CLEAR is dropped.
    assign b_write   = b_valid_q && !bus.cmd_clear;
    assign src       = (fwd_valid_q && (fwd_addr_q == b_addr_q)) ? fwd_value_q : ram_rdata_a;
    assign inc_value = (src == CNT_FULL) ? src : src + 1'b1;

    // Stage-B is never valid while in CLEAR, so the sweep owns the write port.
    assign ram_we    = (state_q == ST_CLEAR) || b_write;
    assign ram_waddr = (state_q == ST_CLEAR) ? sweep_q : b_addr_q;
    assign ram_wdata = (state_q == ST_CLEAR) ? '0 : inc_value;

    mca_dpram #(
        .AW (CH_BITS),
        .DW (CNT_BITS)
    ) u_ram (
        .clk_i     (CLOCK_50),
        .a_we_i    (ram_we),
        .a_waddr_i (ram_waddr),
        .a_wdata_i (ram_wdata),
        .a_raddr_i (bus.event_channel),
        .a_rdata_o (ram_rdata_a),
        .b_addr_i  (bus.channel_address),
        .b_rdata_o (ram_rdata_b)
    );

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        total_d = total_q;

        if (bus.cmd_clear) begin
            state_d = ST_CLEAR;
            sweep_d = '0;
            total_d = '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (sweep_q == ADDR_LAST) begin
                        state_d = ST_IDLE;
                        sweep_d = '0;
                    end else begin
                        sweep_d = sweep_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (bus.cmd_start && !bus.cmd_pause) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.cmd_pause) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_CLEAR;
                    sweep_d = '0;
                end
            endcase

            if (accept && (total_q != CNT_FULL)) begin
                total_d = total_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            sweep_q     <= '0;
            total_q     <= '0;
            b_valid_q   <= 1'b0;
            b_addr_q    <= '0;
            fwd_valid_q <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_value_q <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            total_q     <= total_d;
            b_valid_q   <= accept && !bus.cmd_clear;
            b_addr_q    <= bus.event_channel;
            fwd_valid_q <= b_write;
            fwd_addr_q  <= b_addr_q;
            fwd_value_q <= inc_value;
            rd_valid_q  <= 1'b1;
        end
    end

    // The RAM read register has no reset; hold the host output at zero until
    // the first post-reset read has been captured.
    assign bus.channel_count = rd_valid_q ? ram_rdata_b : '0;
    assign bus.running       = (state_q == ST_RUN);
    assign bus.clearing      = (state_q == ST_CLEAR);
    assign bus.total_events  = total_q;

endmodule

// File: tb/tb_mca_histogram.sv
// ---------------------------------------------------------------------------
// tb_mca_histogram
// Directed bench for mca_histogram. A full-size instance (10-bit channels,
// 32-bit counters) covers sweep, binning, forwarding, pause and clear
// behaviour; a narrow instance (4-bit channels, 4-bit counters) reaches the
// counter saturation limit in a handful of events.
// ---------------------------------------------------------------------------
module tb_mca_histogram;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mca_histogram_if #(.CH_BITS(10), .CNT_BITS(32)) bus ();
    mca_histogram_if #(.CH_BITS(4),  .CNT_BITS(4))  sbus ();

    mca_histogram #(.CH_BITS(10), .CNT_BITS(32)) dut (
        .CLOCK_50 (clk),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    mca_histogram #(.CH_BITS(4), .CNT_BITS(4)) dut_small (
        .CLOCK_50 (clk),
        .rst_n    (rst_n),
        .bus      (sbus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic read_bin(input logic [9:0] ch, output logic [31:0] v);
        bus.channel_address = ch;
        tick();
        v = bus.channel_count;
    endtask

    task automatic read_small(input logic [3:0] ch, output logic [31:0] v);
        sbus.channel_address = ch;
        tick();
        v = {28'd0, sbus.channel_count};
    endtask

    task automatic send_event(input logic [9:0] ch);
        bus.event_valid   = 1'b1;
        bus.event_channel = ch;
        tick();
        bus.event_valid   = 1'b0;
    endtask

    // Counts cycles with clearing high, starting at the current sample.
    task automatic wait_sweep(output int n);
        n = 0;
        while (bus.clearing === 1'b1 && n < 2000) begin
            n++;
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        int          n;

        bus.cmd_start        = 1'b0;
        bus.cmd_pause        = 1'b0;
        bus.cmd_clear        = 1'b0;
        bus.event_valid      = 1'b0;
        bus.event_channel    = '0;
        bus.channel_address  = '0;
        sbus.cmd_start       = 1'b0;
        sbus.cmd_pause       = 1'b0;
        sbus.cmd_clear       = 1'b0;
        sbus.event_valid     = 1'b0;
        sbus.event_channel   = '0;
        sbus.channel_address = '0;

        // 1. reset state, sweep length, swept bin reads zero
        repeat (3) tick();
        check("rst_clearing", {31'd0, bus.clearing}, 32'd1);
        check("rst_running",  {31'd0, bus.running},  32'd0);
        check("rst_total",    bus.total_events,      32'd0);
        check("rst_count",    bus.channel_count,     32'd0);
        rst_n = 1'b1;
        wait_sweep(n);
        check("sweep_len", n, 32'd1024);
        check("sweep_running", {31'd0, bus.running}, 32'd0);
        read_bin(10'h3FF, v);
        check("bin_3ff_zero", v, 32'd0);

        // 2. spaced events on channels 7 and 1000
        bus.cmd_start = 1'b1;
        tick();
        bus.cmd_start = 1'b0;
        check("start_running", {31'd0, bus.running}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            send_event((i < 5) ? 10'd7 : 10'd1000);
            tick();
        end
        repeat (3) tick();
        read_bin(10'd7, v);
        check("bin7_spaced", v, 32'd5);
        read_bin(10'd1000, v);
        check("bin1000_spaced", v, 32'd3);
        check("total_spaced", bus.total_events, 32'd8);

        // 3. back-to-back on 42 with 43 every 10th cycle
        for (int i = 0; i < 100; i++) begin
            bus.event_valid   = 1'b1;
            bus.event_channel = ((i % 10) == 9) ? 10'd43 : 10'd42;
            tick();
        end
        bus.event_valid = 1'b0;
        repeat (3) tick();
        read_bin(10'd42, v);
        check("bin42_fwd", v, 32'd90);
        read_bin(10'd43, v);
        check("bin43_fwd", v, 32'd10);
        check("total_fwd", bus.total_events, 32'd108);

        // 5. pause with an event in the same cycle, dropped events, start+pause
        bus.cmd_pause     = 1'b1;
        bus.event_valid   = 1'b1;
        bus.event_channel = 10'd1000;
        tick();
        bus.cmd_pause = 1'b0;
        check("pause_running", {31'd0, bus.running}, 32'd0);
        bus.event_channel = 10'd7;
        repeat (20) tick();
        bus.cmd_start = 1'b1;
        bus.cmd_pause = 1'b1;
        tick();
        bus.cmd_start   = 1'b0;
        bus.cmd_pause   = 1'b0;
        bus.event_valid = 1'b0;
        check("start_pause_prio", {31'd0, bus.running}, 32'd0);
        repeat (3) tick();
        read_bin(10'd7, v);
        check("bin7_paused", v, 32'd5);
        read_bin(10'd1000, v);
        check("bin1000_pause_cycle", v, 32'd4);
        check("total_paused", bus.total_events, 32'd109);

        // 6. clear mid-run, clear again mid-sweep, reset mid-sweep
        bus.cmd_start = 1'b1;
        tick();
        bus.cmd_start     = 1'b0;
        bus.event_valid   = 1'b1;
        bus.event_channel = 10'd42;
        repeat (10) tick();
        bus.cmd_clear = 1'b1;
        tick();
        bus.cmd_clear = 1'b0;
        check("clear_clearing", {31'd0, bus.clearing}, 32'd1);
        check("clear_total",    bus.total_events,      32'd0);
        check("clear_running",  {31'd0, bus.running},  32'd0);
        repeat (500) tick();
        bus.cmd_clear = 1'b1;
        tick();
        bus.cmd_clear = 1'b0;
        repeat (1000) tick();
        check("clear_restart", {31'd0, bus.clearing}, 32'd1);
        bus.event_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        check("rst2_clearing", {31'd0, bus.clearing}, 32'd1);
        rst_n = 1'b1;
        wait_sweep(n);
        check("sweep2_len", n, 32'd1024);
        check("final_running", {31'd0, bus.running}, 32'd0);
        check("final_total",   bus.total_events,     32'd0);
        read_bin(10'd7, v);
        check("final_bin7", v, 32'd0);
        read_bin(10'd42, v);
        check("final_bin42", v, 32'd0);
        read_bin(10'd1000, v);
        check("final_bin1000", v, 32'd0);

        // 4. saturation on the narrow instance (4-bit counters, max 15)
        sbus.cmd_start = 1'b1;
        tick();
        sbus.cmd_start = 1'b0;
        check("small_running", {31'd0, sbus.running}, 32'd1);
        sbus.event_channel = 4'd5;
        sbus.event_valid   = 1'b1;
        repeat (14) tick();
        sbus.event_valid = 1'b0;
        repeat (3) tick();
        read_small(4'd5, v);
        check("small_bin5_pre", v, 32'd14);
        check("small_total_pre", {28'd0, sbus.total_events}, 32'd14);
        sbus.event_valid = 1'b1;
        repeat (3) tick();
        sbus.event_valid = 1'b0;
        repeat (3) tick();
        read_small(4'd5, v);
        check("small_bin5_sat", v, 32'd15);
        check("small_total_sat", {28'd0, sbus.total_events}, 32'd15);
        read_small(4'd6, v);
        check("small_bin6_zero", v, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
